// File: rtl/ddr_pkg.sv
// Shared DDR constants, arbiter state encoding and round-robin helper.
package ddr_pkg;

  localparam int DDR_ADDR_W           = 24;
  localparam int DDR_DATA_W           = 32;
  localparam int DDR_REFRESH_INTERVAL = 780;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    ACK
  } arb_state_e;

  // 1 = grant requester 1; on a tie the requester not served last wins
  function automatic logic rr_pick(input logic r0, input logic r1,
                                   input logic last);
    return r1 & (~r0 | ~last);
  endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh countdown with a pending request flag
// and a sticky late flag for intervals that expire unserviced.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int INTERVAL = DDR_REFRESH_INTERVAL
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic pending,
  output logic late
);

  localparam int CW = $clog2(INTERVAL + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          late_q, late_d;
  logic          expire;

  // a new expiry beats a same-cycle clear
  always_comb begin
    expire    = (cnt_q == '0);
    cnt_d     = expire ? CW'(INTERVAL - 1) : cnt_q - 1'b1;
    pending_d = expire | (pending_q & ~clear);
    late_d    = late_q | (expire & pending_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= CW'(INTERVAL - 1);
      pending_q <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      late_q    <= late_d;
    end
  end

  assign pending = pending_q;
  assign late    = late_q;

endmodule

// File: rtl/ddr_arbiter.sv
// DDR command arbiter: two round-robin requesters plus periodic auto-refresh.
// One command outstanding at a time; refresh never preempts a transaction.
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int ADDR_WIDTH       = DDR_ADDR_W,
  parameter int DATA_WIDTH       = DDR_DATA_W,
  parameter int REFRESH_INTERVAL = DDR_REFRESH_INTERVAL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  write0,
  input  logic                  write1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_write,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  cmd_refresh,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  refresh_late
);

  arb_state_e            state_q, state_d;
  logic                  gnt1_q, gnt1_d;
  logic                  last_q, last_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_write_q, cmd_write_d;
  logic                  cmd_refresh_q, cmd_refresh_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  ref_pending, ref_clear, pick1;

  ddr_refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .clock  (clock),
    .reset  (reset),
    .clear  (ref_clear),
    .pending(ref_pending),
    .late   (refresh_late)
  );

  always_comb begin
    pick1         = rr_pick(req0, req1, last_q);
    state_d       = state_q;
    gnt1_d        = gnt1_q;
    last_d        = last_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_write_d   = cmd_write_q;
    cmd_refresh_d = cmd_refresh_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    rdata_d       = rdata_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    ref_clear     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ref_pending) begin
          state_d       = ISSUE;
          cmd_valid_d   = 1'b1;
          cmd_refresh_d = 1'b1;
          cmd_write_d   = 1'b0;
        end else if (req0 | req1) begin
          state_d       = ISSUE;
          cmd_valid_d   = 1'b1;
          cmd_refresh_d = 1'b0;
          gnt1_d        = pick1;
          last_d        = pick1;
          cmd_write_d   = pick1 ? write1 : write0;
          cmd_addr_d    = pick1 ? addr1 : addr0;
          cmd_wdata_d   = pick1 ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d     = WAIT_RSP;
          cmd_valid_d = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          if (cmd_refresh_q) begin
            state_d       = IDLE;
            ref_clear     = 1'b1;
            cmd_refresh_d = 1'b0;
          end else begin
            state_d = ACK;
            rdata_d = rsp_rdata;
            ack0_d  = ~gnt1_q;
            ack1_d  = gnt1_q;
          end
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt1_q        <= 1'b0;
      last_q        <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_refresh_q <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      rdata_q       <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt1_q        <= gnt1_d;
      last_q        <= last_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_write_q   <= cmd_write_d;
      cmd_refresh_q <= cmd_refresh_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      rdata_q       <= rdata_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_wdata   = cmd_wdata_q;
  assign cmd_refresh = cmd_refresh_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Scoreboard bench for ddr_arbiter: directed transactions, expected
// commands/acks queued with hand-computed cycle numbers.
module tb_ddr_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RI = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          write0 = 1'b0, write1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic          cmd_valid, cmd_write, cmd_refresh;
  logic          cmd_ready = 1'b1;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_rdata = '0;
  logic          refresh_late;

  always #5 clock = ~clock;

  ddr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_INTERVAL(RI)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .write0(write0), .write1(write1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_refresh(cmd_refresh),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .refresh_late(refresh_late)
  );

  typedef struct {
    logic          refr;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } cmd_t;

  typedef struct {
    int            who;
    logic          chk;
    logic [DW-1:0] rdata;
    int            cyc;
  } ack_t;

  cmd_t exp_cmd[$];
  ack_t exp_ack[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // cycles since reset release: after the k-th active edge cyc == k
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void xc(input logic refr, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int c);
    cmd_t e;
    e = '{refr, wr, a, d, c};
    exp_cmd.push_back(e);
  endfunction

  function automatic void xa(input int who, input logic chk,
                             input logic [DW-1:0] r, input int c);
    ack_t e;
    e = '{who, chk, r, c};
    exp_ack.push_back(e);
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (a == 24'h000010) return 32'hDEADBEEF;
    return {8'hC0, a};
  endfunction

  // DDR controller model: response one cycle after command acceptance
  logic          acc = 1'b0;
  logic [DW-1:0] acc_data = '0;
  always @(negedge clock) begin
    #1;
    if (reset) begin
      rsp_valid = 1'b0;
      acc       = 1'b0;
    end else begin
      rsp_valid = acc;
      rsp_rdata = acc ? acc_data : '0;
      acc       = cmd_valid && cmd_ready;
      acc_data  = mem_rd(cmd_addr);
    end
  end

  // monitor
  always @(negedge clock) begin
    #1;
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cmd_unexpected at cyc %0d: refresh=%0b addr=%0h, none required",
                   cyc, cmd_refresh, cmd_addr);
        end else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          check("cmd_cyc", 64'(cyc), 64'(e.cyc));
          check("cmd_refresh", 64'(cmd_refresh), 64'(e.refr));
          if (!e.refr) begin
            check("cmd_write", 64'(cmd_write), 64'(e.wr));
            check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
            if (e.wr) check("cmd_wdata", 64'(cmd_wdata), 64'(e.wdata));
          end
        end
      end
      if (ack0 && ack1) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_both at cyc %0d: ack0=1 ack1=1, at most one required", cyc);
      end else if (ack0 || ack1) begin
        if (exp_ack.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ack_unexpected at cyc %0d: ack0=%0b ack1=%0b, none required",
                   cyc, ack0, ack1);
        end else begin
          ack_t e;
          e = exp_ack.pop_front();
          check("ack_who", ack1 ? 64'd1 : 64'd0, 64'(e.who));
          check("ack_cyc", 64'(cyc), 64'(e.cyc));
          if (e.chk) check("ack_rdata", 64'(rdata), 64'(e.rdata));
        end
      end
    end
  end

  task automatic drive(input int id, input logic r, input logic [AW-1:0] a,
                       input logic w, input logic [DW-1:0] d);
    if (id == 0) begin
      req0 = r; addr0 = a; write0 = w; wdata0 = d;
    end else begin
      req1 = r; addr1 = a; write1 = w; wdata1 = d;
    end
  endtask

  task automatic requester(input int id, input int n, input logic [AW-1:0] base,
                           input logic w, input int start);
    while (cyc < start) @(negedge clock);
    for (int i = 0; i < n; i++) begin
      int   t;
      logic got;
      drive(id, 1'b1, base + AW'(4 * i), w,
            (id == 0 ? 32'hA000_0000 : 32'hB000_0000) + DW'(i));
      got = 1'b0;
      t   = 0;
      while (!got && t < 200) begin
        @(negedge clock);
        t++;
        got = (id == 0) ? ack0 : ack1;
      end
      if (!got) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_timeout: requester %0d got no ack in 200 cycles, ack required", id);
        break;
      end
    end
    drive(id, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic leftover();
    n_cmp++;
    if (exp_cmd.size() != 0 || exp_ack.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d cmd and %0d ack expectations unmet, 0 required",
               exp_cmd.size(), exp_ack.size());
    end
    exp_cmd.delete();
    exp_ack.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    leftover();
    reset = 1'b1;
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    cmd_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_ctl"},
          64'({ack0, ack1, cmd_valid, cmd_refresh, cmd_write, refresh_late}), 64'd0);
    check({tag, "_addr"}, 64'(cmd_addr), 64'd0);
    check({tag, "_wdata"}, 64'(cmd_wdata), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, $finish required");
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    chk_rst("reset");

    // single read, minimum latency
    xc(1'b0, 1'b0, 24'h000010, '0, 1);
    xa(0, 1'b1, 32'hDEADBEEF, 3);
    requester(0, 1, 24'h000010, 1'b0, 0);
    while (cyc < 8) @(negedge clock);
    do_reset();

    // both requesters continuously: 0,1,0,1 then refresh at cyc 17
    xc(1'b0, 1'b0, 24'h000100, '0, 1);
    xc(1'b0, 1'b1, 24'h000200, 32'hB000_0000, 5);
    xc(1'b0, 1'b0, 24'h000104, '0, 9);
    xc(1'b0, 1'b1, 24'h000204, 32'hB000_0001, 13);
    xc(1'b1, 1'b0, '0, '0, 17);
    xa(0, 1'b1, 32'hC000_0100, 3);
    xa(1, 1'b0, '0, 7);
    xa(0, 1'b1, 32'hC000_0104, 11);
    xa(1, 1'b0, '0, 15);
    fork
      requester(0, 2, 24'h000100, 1'b0, 0);
      requester(1, 2, 24'h000200, 1'b1, 0);
    join
    while (cyc < 22) @(negedge clock);
    do_reset();

    // idle: refresh every 16 cycles, no acks
    xc(1'b1, 1'b0, '0, '0, 17);
    xc(1'b1, 1'b0, '0, '0, 33);
    xc(1'b1, 1'b0, '0, '0, 49);
    while (cyc < 60) @(negedge clock);
    check("late_idle", 64'(refresh_late), 64'd0);
    do_reset();

    // refresh expires during req1 write; beats waiting req0
    xc(1'b0, 1'b1, 24'h000300, 32'hB000_0000, 14);
    xc(1'b1, 1'b0, '0, '0, 18);
    xc(1'b0, 1'b0, 24'h000400, '0, 21);
    xa(1, 1'b0, '0, 16);
    xa(0, 1'b1, 32'hC000_0400, 23);
    fork
      requester(1, 1, 24'h000300, 1'b1, 13);
      requester(0, 1, 24'h000400, 1'b0, 14);
    join
    while (cyc < 28) @(negedge clock);
    do_reset();

    // controller stalls 50 cycles: command held, refresh goes late
    cmd_ready = 1'b0;
    xc(1'b0, 1'b1, 24'h000500, 32'hA000_0000, 51);
    xa(0, 1'b0, '0, 53);
    xc(1'b1, 1'b0, '0, '0, 55);
    fork
      requester(0, 1, 24'h000500, 1'b1, 0);
      begin
        for (int k = 1; k <= 50; k++) begin
          while (cyc < k) @(negedge clock);
          check("hold_cmd",
                64'({cmd_valid, cmd_refresh, cmd_write, cmd_addr, cmd_wdata}),
                64'({1'b1, 1'b0, 1'b1, 24'h000500, 32'hA000_0000}));
          if (k == 20) check("late_pending_only", 64'(refresh_late), 64'd0);
          if (k == 31) check("late_before_expiry", 64'(refresh_late), 64'd0);
          if (k == 32) check("late_at_expiry", 64'(refresh_late), 64'd1);
        end
        check("late_stall_end", 64'(refresh_late), 64'd1);
        while (cyc < 51) @(negedge clock);
        cmd_ready = 1'b1;
      end
    join
    while (cyc < 58) @(negedge clock);
    check("late_sticky", 64'(refresh_late), 64'd1);
    do_reset();
    #1;
    check("late_cleared", 64'(refresh_late), 64'd0);

    // reset during WAIT_RSP: transaction abandoned, no ack
    xc(1'b0, 1'b0, 24'h000600, '0, 1);
    drive(0, 1'b1, 24'h000600, 1'b0, '0);
    while (cyc < 2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk_rst("midreset");
    drive(0, 1'b0, '0, 1'b0, '0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    chk_rst("post_reset");
    leftover();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
